imem_fetch_ctrl: RTL and testbench

- Sequences the 24-bit, 1024-word instruction memory.
- Owns the program counter, drives the word address and waits a fixed number of cycles for read data to settle. It then captures each instruction, with its PC, into a 2-entry output FIFO.
- Presents instructions to decode over a valid/ready handshake. Decode/execute can redirect the PC (branch or jump) or halt fetch.

---
 rtl/imem_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, waits MEM_LAT cycles per read, captures into a 2-entry FIFO.
// Latency: first out_valid MEM_LAT+1 cycles after issue; redirect flushes everything and wins over halt/capture/pop.
module imem_fetch_ctrl #(
    parameter int N        = 24,
    parameter int AW       = 10,
    parameter int MEM_LAT  = 2,
    parameter int RESET_PC = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_instr,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    input  logic         halt,
    output logic         out_valid,
    output logic [N-1:0] out_instr,
    output logic [N-1:0] out_pc,
    input  logic         out_ready,
    output logic         busy
);
    localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HALTED} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_pc;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;

    logic            r_out_vld;
    logic [N-1:0]    r_out_instr;
    logic [AW-1:0]   r_out_pc;
    logic            r_sk_vld;
    logic [N-1:0]    r_sk_instr;
    logic [AW-1:0]   r_sk_pc;

    logic            w_pop;
    logic            w_cap;
    logic            w_push;
    logic [1:0]      w_cnt_now;
    logic [1:0]      w_cnt_post;
    logic            w_unused_redirect_hi;

    assign w_pop      = r_out_vld & out_ready;
    assign w_cap      = (r_state == S_WAIT) && (r_cnt == CW'(MEM_LAT));
    assign w_push     = w_cap & ~redirect_valid;
    assign w_cnt_now  = {1'b0, r_out_vld} + {1'b0, r_sk_vld};
    // Capture only happens with at most one entry held, so this never exceeds 2.
    assign w_cnt_post = w_cnt_now + {1'b0, w_cap} - {1'b0, w_pop};
    assign w_unused_redirect_hi = ^redirect_pc[N-1:AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_pc    <= AW'(RESET_PC);
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else if (redirect_valid) begin
            r_pc    <= redirect_pc[AW-1:0];
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= halt ? S_HALTED : S_FETCH;
        end else begin
            case (r_state)
                S_FETCH, S_HALTED: begin
                    // Leaving HALTED issues immediately so resume latency matches a cold start.
                    if (halt) begin
                        r_state <= S_HALTED;
                    end else if (w_cnt_now < 2'd2) begin
                        r_state <= S_WAIT;
                        r_cnt   <= CW'(1);
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_WAIT: begin
                    if (w_cap) begin
                        r_pc <= r_pc + AW'(1);
                        if (!halt && (w_cnt_post < 2'd2)) begin
                            r_cnt <= CW'(1);
                        end else begin
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                            r_state <= halt ? S_HALTED : S_FETCH;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld   <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
            r_sk_vld    <= 1'b0;
            r_sk_instr  <= '0;
            r_sk_pc     <= '0;
        end else if (redirect_valid) begin
            r_out_vld <= 1'b0;
            r_sk_vld  <= 1'b0;
        end else if (w_pop) begin
            if (r_sk_vld) begin
                r_out_instr <= r_sk_instr;
                r_out_pc    <= r_sk_pc;
                r_out_vld   <= 1'b1;
                if (w_push) begin
                    r_sk_instr <= imem_instr;
                    r_sk_pc    <= r_pc;
                end else begin
                    r_sk_vld <= 1'b0;
                end
            end else if (w_push) begin
                r_out_instr <= imem_instr;
                r_out_pc    <= r_pc;
            end else begin
                r_out_vld <= 1'b0;
            end
        end else if (w_push) begin
            if (!r_out_vld) begin
                r_out_instr <= imem_instr;
                r_out_pc    <= r_pc;
                r_out_vld   <= 1'b1;
            end else begin
                r_sk_instr <= imem_instr;
                r_sk_pc    <= r_pc;
                r_sk_vld   <= 1'b1;
            end
        end
    end

    assign imem_addr = {{(N-AW){1'b0}}, r_pc};
    assign out_valid = r_out_vld;
    assign out_instr = r_out_instr;
    assign out_pc    = {{(N-AW){1'b0}}, r_out_pc};
    assign busy      = r_busy;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a combinational memory model word[i] = i + 0x100.
module tb_imem_fetch_ctrl;
    logic        clk;
    logic        rst_n;
    logic [23:0] imem_addr;
    logic [23:0] imem_instr;
    logic        redirect_valid;
    logic [23:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic [23:0] out_instr;
    logic [23:0] out_pc;
    logic        out_ready;
    logic        busy;

    logic [23:0] mem [1024];
    logic [23:0] q_pc [$];
    logic [23:0] q_ins [$];
    int n_vec;
    int n_err;

    imem_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready), .busy(busy)
    );

    assign imem_instr = mem[imem_addr[9:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record the beat accepted at the coming edge, then advance to 1 ns after it.
    task automatic step();
        if (out_valid && out_ready) begin
            q_pc.push_back(out_pc);
            q_ins.push_back(out_instr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q_pc.delete();
        q_ins.delete();
        rst_n = 1'b1;
    endtask

    task automatic collect(input int n);
        int t;
        t = 0;
        while (q_pc.size() < n && t < 200) begin
            step();
            t++;
        end
        n_vec++;
        if (q_pc.size() < n) begin
            n_err++;
            $display("FAIL collect: got %0d beats, required %0d", q_pc.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = 1'b0;
        #3;
        n_vec++;
        if ({out_valid, busy, out_instr, out_pc, imem_addr} !== 74'd0) begin
            n_err++;
            $display("FAIL reset_state: valid=%0b busy=%0b instr=%h pc=%h addr=%h, required all 0",
                     out_valid, busy, out_instr, out_pc, imem_addr);
        end
    endtask

    task automatic test_stream();
        int t;
        apply_reset();
        out_ready = 1'b1;
        t = 0;
        while (!out_valid && t < 20) begin step(); t++; end
        n_vec++;
        if (t !== 3) begin n_err++; $display("FAIL first_valid_latency: %0d, required 3", t); end
        n_vec++;
        if (out_pc !== 24'd0 || out_instr !== 24'h000100) begin
            n_err++; $display("FAIL first_beat: pc=%h instr=%h, required 0/000100", out_pc, out_instr);
        end
        step();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_gap: valid=%0b, required 0", out_valid); end
        step();
        n_vec++;
        if (out_valid !== 1'b1 || out_pc !== 24'd1 || out_instr !== 24'h000101) begin
            n_err++; $display("FAIL second_beat: v=%0b pc=%h instr=%h, required 1/1/000101", out_valid, out_pc, out_instr);
        end
        repeat (2) step();
        n_vec++;
        if (out_valid !== 1'b1 || out_pc !== 24'd2 || out_instr !== 24'h000102) begin
            n_err++; $display("FAIL third_beat: v=%0b pc=%h instr=%h, required 1/2/000102", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        repeat (10) step();
        n_vec++;
        if (out_valid !== 1'b1 || out_pc !== 24'd0 || out_instr !== 24'h000100) begin
            n_err++; $display("FAIL bp_hold: v=%0b pc=%h instr=%h, required 1/0/000100", out_valid, out_pc, out_instr);
        end
        n_vec++;
        if (busy !== 1'b0 || imem_addr !== 24'd2) begin
            n_err++; $display("FAIL bp_idle: busy=%0b addr=%h, required 0/2", busy, imem_addr);
        end
        out_ready = 1'b1;
        collect(3);
        for (int i = 0; i < 3 && i < q_pc.size(); i++) begin
            n_vec++;
            if (q_pc[i] !== 24'(i) || q_ins[i] !== 24'(i + 'h100)) begin
                n_err++; $display("FAIL bp_order[%0d]: pc=%h instr=%h, required %h/%h", i, q_pc[i], q_ins[i], i, i + 'h100);
            end
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        out_ready = 1'b0;
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc = 24'hFFF3FF;
        step();
        redirect_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || imem_addr !== 24'h0003FF) begin
            n_err++; $display("FAIL redirect_flush: v=%0b busy=%0b addr=%h, required 0/0/0003ff", out_valid, busy, imem_addr);
        end
        out_ready = 1'b1;
        collect(2);
        n_vec++;
        if (q_pc.size() < 2 || q_pc[0] !== 24'h3FF || q_ins[0] !== 24'h0004FF || q_pc[1] !== 24'h0 || q_ins[1] !== 24'h000100) begin
            n_err++; $display("FAIL redirect_wrap: beats=%p instrs=%p, required 3ff/4ff then 0/100", q_pc, q_ins);
        end
    endtask

    task automatic test_redirect_pop();
        int t;
        apply_reset();
        out_ready = 1'b1;
        t = 0;
        while (!(out_valid && out_pc == 24'd4) && t < 40) begin step(); t++; end
        redirect_valid = 1'b1;
        redirect_pc = 24'h000050;
        step();
        redirect_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rp_flush: valid=%0b, required 0", out_valid); end
        collect(6);
        n_vec++;
        if (q_pc.size() < 6 || q_pc[0] !== 24'd0 || q_pc[1] !== 24'd1 || q_pc[2] !== 24'd2 || q_pc[3] !== 24'd3 ||
            q_pc[4] !== 24'd4 || q_pc[5] !== 24'h50 || q_ins[5] !== 24'h000150) begin
            n_err++; $display("FAIL rp_sequence: pcs=%p, required 0,1,2,3,4,50 (instr 150)", q_pc);
        end
    endtask

    task automatic test_halt();
        int t;
        int bad;
        apply_reset();
        out_ready = 1'b1;
        t = 0;
        while (!(busy && imem_addr == 24'd7) && t < 40) begin step(); t++; end
        halt = 1'b1;
        t = 0;
        while (busy && t < 10) begin step(); t++; end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b0 || imem_addr !== 24'd8) bad++;
            step();
        end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL halt_idle: %0d bad cycles (busy=%0b addr=%h), required busy 0 addr 8", bad, busy, imem_addr); end
        n_vec++;
        if (q_pc.size() == 0 || q_pc[$] !== 24'd7) begin
            n_err++; $display("FAIL halt_last: last pc=%h, required 7", (q_pc.size() != 0) ? q_pc[$] : 24'hx);
        end
        halt = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin step(); t++; end
        n_vec++;
        if (t !== 3 || out_pc !== 24'd8 || out_instr !== 24'h000108) begin
            n_err++; $display("FAIL halt_resume: latency=%0d pc=%h instr=%h, required 3/8/000108", t, out_pc, out_instr);
        end
    endtask

    task automatic test_async_reset();
        int t;
        apply_reset();
        out_ready = 1'b0;
        repeat (4) step();
        n_vec++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            n_err++; $display("FAIL ar_pre: v=%0b busy=%0b, required 1/1", out_valid, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || imem_addr !== 24'd0 || busy !== 1'b0) begin
            n_err++; $display("FAIL ar_immediate: v=%0b addr=%h busy=%0b, required 0/0/0", out_valid, imem_addr, busy);
        end
        @(posedge clk);
        #1;
        q_pc.delete();
        q_ins.delete();
        rst_n = 1'b1;
        out_ready = 1'b1;
        t = 0;
        while (!out_valid && t < 20) begin step(); t++; end
        n_vec++;
        if (t !== 3 || out_pc !== 24'd0 || out_instr !== 24'h000100) begin
            n_err++; $display("FAIL ar_restart: latency=%0d pc=%h instr=%h, required 3/0/000100", t, out_pc, out_instr);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 24'(i + 'h100);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_halt();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
